// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and the result flag bundle.
package alu_seq_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOT = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7,
    OP_ASR = 4'd8,
    OP_ROL = 4'd9,
    OP_ROR = 4'd10,
    OP_MUL = 4'd11
  } alu_op_e;

  typedef enum logic {
    ST_IDLE,
    ST_MUL
  } state_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic negative;
    logic overflow;
    logic err;
  } alu_flags_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between the operand source, the ALU and the result sink.
interface alu_seq_if #(parameter int WIDTH = 8);
  import alu_seq_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [OP_W-1:0]  op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             negative;
  logic             overflow;
  logic             err;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, carry, zero, negative, overflow, err
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, carry, zero, negative, overflow, err
  );

endinterface

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles per multiply.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  import alu_seq_pkg::*;

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // product is the accumulator after this cycle's step, so the last step is usable as it happens
  assign product = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done    = (cnt_q == CNT_W'(1));

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (start) begin
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = CNT_W'(WIDTH);
    end else if (cnt_q != '0) begin
      acc_d    = product;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready in and out; single-cycle ops plus a multi-cycle unsigned multiply.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);
  import alu_seq_pkg::*;

  state_e             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  alu_flags_t         flags_q, flags_d;

  logic               in_ready;
  logic               accept;
  logic               is_mul;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic               alu_ovf;
  logic               alu_err;
  logic               mul_hi;

  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign is_mul   = (bus.op == OP_MUL);
  assign sum      = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff     = {1'b0, bus.a} - {1'b0, bus.b};
  assign mul_hi   = |mul_product[2*WIDTH-1:WIDTH];

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && is_mul),
    .a       (bus.a),
    .b       (bus.b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_err   = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = diff[WIDTH-1:0];
        alu_carry = diff[WIDTH];
        alu_ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND: alu_res = bus.a & bus.b;
      OP_OR:  alu_res = bus.a | bus.b;
      OP_XOR: alu_res = bus.a ^ bus.b;
      OP_NOT: alu_res = ~bus.a;
      OP_SHL: begin
        alu_res   = {bus.a[WIDTH-2:0], 1'b0};
        alu_carry = bus.a[WIDTH-1];
      end
      OP_SHR: begin
        alu_res   = {1'b0, bus.a[WIDTH-1:1]};
        alu_carry = bus.a[0];
      end
      OP_ASR: begin
        alu_res   = {bus.a[WIDTH-1], bus.a[WIDTH-1:1]};
        alu_carry = bus.a[0];
      end
      OP_ROL: begin
        alu_res   = {bus.a[WIDTH-2:0], bus.a[WIDTH-1]};
        alu_carry = bus.a[WIDTH-1];
      end
      OP_ROR: begin
        alu_res   = {bus.a[0], bus.a[WIDTH-1:1]};
        alu_carry = bus.a[0];
      end
      OP_MUL: alu_res = '0;
      default: alu_err = 1'b1;
    endcase
  end

  // A pending result drains on out_ready; a new load in the same cycle simply replaces it
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_mul) begin
            state_d = ST_MUL;
          end else begin
            result_d    = alu_res;
            flags_d     = '{carry: alu_carry, zero: (alu_res == '0), negative: alu_res[WIDTH-1],
                            overflow: alu_ovf, err: alu_err};
            out_valid_d = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          result_d    = mul_product[WIDTH-1:0];
          flags_d     = '{carry: mul_hi, zero: (mul_product[WIDTH-1:0] == '0),
                          negative: mul_product[WIDTH-1], overflow: mul_hi, err: 1'b0};
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.carry     = flags_q.carry;
  assign bus.zero      = flags_q.zero;
  assign bus.negative  = flags_q.negative;
  assign bus.overflow  = flags_q.overflow;
  assign bus.err       = flags_q.err;

endmodule
